// File: rtl/apb_i2c_csr.sv
// apb_i2c_csr: APB3 register block for the I2C master core.
// Provides TX/RX byte FIFOs, sticky W1C status, FIFO levels, flush controls,
// a busy/start interlock and PSLVERR reporting. Single clock domain (PCLK).
// Optional interrupt output and IRQ_EN register (offset 0x18) are built only
// when the macro I2C_CSR_IRQ_EN is defined.

// Circular-buffer FIFO with a level counter; head is read combinationally.
module apb_i2c_csr_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LVL_W  = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the pre-edge level, so a full FIFO rejects a push
  // even when a pop lands in the same cycle.
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign level   = level_reg;
  assign rdata   = mem[rd_ptr_reg];

  // Pointer and level update; flush overrides any concurrent push or pop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage array; contents need no reset since the level qualifies them.
  always_ff @(posedge PCLK) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= wdata;
  end
endmodule

// Register block top level.
module apb_i2c_csr #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              i2c_start,
  output logic [7:0]        i2c_addr,
  output logic [CNT_W-1:0]  i2c_cnt,
  input  logic              i2c_tx_rd,
  output logic [DATA_W-1:0] i2c_tx_data,
  output logic              i2c_tx_empty,
  input  logic              i2c_rx_wr,
  input  logic [DATA_W-1:0] i2c_rx_data,
  input  logic              i2c_done
`ifdef I2C_CSR_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam logic [2:0] OFF_ADDR   = 3'd0;
  localparam logic [2:0] OFF_TXDATA = 3'd1;
  localparam logic [2:0] OFF_CNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_RXDATA = 3'd5;
  localparam logic [2:0] OFF_IRQEN  = 3'd6;

  logic [2:0]        offset;
  logic              access, wr_en, rd_en;
  logic              unmapped, err, wr_ok, rd_ok;
  logic              tx_push, ctrl_wr, start_cmd, tx_flush, rx_flush, rx_pop;
  logic              status_w1c, rx_ovf_set;
  logic [7:0]        addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg, start_reg, done_reg, rx_ovf_reg;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [LVL_W-1:0]  tx_level, rx_level;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [31:0]       status_word, rdata_mux;
  logic              unused_bits;

  assign offset = PADDR[4:2];
  assign access = PSEL & PENABLE;
  assign wr_en  = access & PWRITE;
  assign rd_en  = access & ~PWRITE;

`ifdef I2C_CSR_IRQ_EN
  assign unmapped = (offset == 3'd7);
`else
  assign unmapped = (offset == 3'd7) || (offset == OFF_IRQEN);
`endif

  // Any error condition suppresses every side effect of the access.
  assign err = access & (unmapped
             | (wr_en & (offset == OFF_TXDATA) & tx_full)
             | (rd_en & (offset == OFF_RXDATA) & rx_empty)
             | (wr_en & (offset == OFF_CTRL) & PWDATA[0] & busy_reg));

  assign wr_ok      = wr_en & ~err;
  assign rd_ok      = rd_en & ~err;
  assign tx_push    = wr_ok & (offset == OFF_TXDATA);
  assign ctrl_wr    = wr_ok & (offset == OFF_CTRL);
  assign start_cmd  = ctrl_wr & PWDATA[0];
  assign tx_flush   = ctrl_wr & PWDATA[1];
  assign rx_flush   = ctrl_wr & PWDATA[2];
  assign rx_pop     = rd_ok & (offset == OFF_RXDATA);
  assign status_w1c = wr_ok & (offset == OFF_STATUS);
  assign rx_ovf_set = i2c_rx_wr & rx_full;

  assign PREADY       = 1'b1;
  assign PSLVERR      = err;
  assign i2c_start    = start_reg;
  assign i2c_addr     = addr_reg;
  assign i2c_cnt      = cnt_reg;
  assign i2c_tx_data  = tx_head;
  assign i2c_tx_empty = tx_empty;
  assign unused_bits  = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  apb_i2c_csr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .push(tx_push), .pop(i2c_tx_rd), .flush(tx_flush),
    .wdata(PWDATA[DATA_W-1:0]), .rdata(tx_head),
    .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  apb_i2c_csr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .push(i2c_rx_wr), .pop(rx_pop), .flush(rx_flush),
    .wdata(i2c_rx_data), .rdata(rx_head),
    .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  // Plain RW configuration registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (wr_ok && offset == OFF_ADDR) addr_reg <= PWDATA[7:0];
      if (wr_ok && offset == OFF_CNT)  cnt_reg  <= PWDATA[CNT_W-1:0];
    end
  end

  // Start interlock and sticky status; hardware set wins over a W1C.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      start_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      rx_ovf_reg <= 1'b0;
    end else begin
      start_reg <= start_cmd;
      if (start_cmd)     busy_reg <= 1'b1;
      else if (i2c_done) busy_reg <= 1'b0;
      if (i2c_done)                       done_reg <= 1'b1;
      else if (status_w1c && PWDATA[0])   done_reg <= 1'b0;
      if (rx_ovf_set)                     rx_ovf_reg <= 1'b1;
      else if (status_w1c && PWDATA[6])   rx_ovf_reg <= 1'b0;
    end
  end

  assign status_word = {8'h00, 8'(rx_level), 8'(tx_level), 1'b0, rx_ovf_reg,
                        rx_empty, rx_full, tx_empty, tx_full, busy_reg, done_reg};

`ifdef I2C_CSR_IRQ_EN
  logic [3:0] irq_en_reg;
  logic       irq_reg;

  assign irq = irq_reg;

  // Interrupt enables and registered interrupt output.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ok && offset == OFF_IRQEN) irq_en_reg <= PWDATA[3:0];
      irq_reg <= |(irq_en_reg & {~rx_empty, tx_empty, rx_ovf_reg, done_reg});
    end
  end
`endif

  // Read-data mux; write-only and unmapped locations read as zero.
  always_comb begin
    rdata_mux = '0;
    case (offset)
      OFF_ADDR:   rdata_mux = {24'h0, addr_reg};
      OFF_CNT:    rdata_mux = 32'(cnt_reg);
      OFF_STATUS: rdata_mux = status_word;
      OFF_RXDATA: rdata_mux = 32'(rx_head);
`ifdef I2C_CSR_IRQ_EN
      OFF_IRQEN:  rdata_mux = {28'h0, irq_en_reg};
`endif
      default:    rdata_mux = '0;
    endcase
  end

  assign PRDATA = rd_ok ? rdata_mux : 32'h0;
endmodule

// File: tb/tb_apb_i2c_csr.sv
// Directed testbench for apb_i2c_csr (default parameters).
// Covers reset, FIFO fill/drain, start interlock, RX overflow, same-cycle
// corner cases and the optional I2C_CSR_IRQ_EN register.
module tb_apb_i2c_csr;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        i2c_start;
  logic [7:0]  i2c_addr, i2c_cnt;
  logic        i2c_tx_rd = 1'b0;
  logic [7:0]  i2c_tx_data;
  logic        i2c_tx_empty;
  logic        i2c_rx_wr = 1'b0;
  logic [7:0]  i2c_rx_data = '0;
  logic        i2c_done = 1'b0;
`ifdef I2C_CSR_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  apb_i2c_csr dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .i2c_start(i2c_start),
    .i2c_addr(i2c_addr), .i2c_cnt(i2c_cnt), .i2c_tx_rd(i2c_tx_rd),
    .i2c_tx_data(i2c_tx_data), .i2c_tx_empty(i2c_tx_empty),
    .i2c_rx_wr(i2c_rx_wr), .i2c_rx_data(i2c_rx_data), .i2c_done(i2c_done)
`ifdef I2C_CSR_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) if (i2c_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One APB transfer; core-side strobes are held only during the access phase.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit c_done, input bit c_txrd, input bit c_rxwr,
                          input logic [7:0] c_rxdata,
                          output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    i2c_done = c_done; i2c_tx_rd = c_txrd; i2c_rx_wr = c_rxwr; i2c_rx_data = c_rxdata;
    #1;
    rdata = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    i2c_done = 1'b0; i2c_tx_rd = 1'b0; i2c_rx_wr = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] d;
    apb_xfer(1'b1, addr, wdata, 1'b0, 1'b0, 1'b0, 8'h00, d, err);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
    apb_xfer(1'b0, addr, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, rdata, err);
  endtask

  // One cycle of core-side strobes with the APB bus idle.
  task automatic core_cycle(input bit c_done, input bit c_txrd, input bit c_rxwr, input logic [7:0] c_rxdata);
    i2c_done = c_done; i2c_tx_rd = c_txrd; i2c_rx_wr = c_rxwr; i2c_rx_data = c_rxdata;
    @(posedge PCLK); #1;
    i2c_done = 1'b0; i2c_tx_rd = 1'b0; i2c_rx_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          snap;

    // 1. reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_start", 32'(i2c_start), 32'h0);
    check("rst_tx_empty", 32'(i2c_tx_empty), 32'h1);
    check("rst_prdata_idle", PRDATA, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_read(32'h0C, rd, err);
    check("rst_status", rd, 32'h0000_0028);
    check("rst_status_err", 32'(err), 32'h0);

    // 2. TX fill to full, overflow write, drain
    for (int i = 0; i < 8; i++) begin
      apb_write(32'h04, 32'h11 + 32'(i), err);
      check("tx_push_err", 32'(err), 32'h0);
    end
    apb_read(32'h0C, rd, err);
    check("tx_full_status", rd, 32'h0000_0824);
    apb_write(32'h04, 32'h99, err);
    check("tx_push_full_err", 32'(err), 32'h1);
    apb_read(32'h0C, rd, err);
    check("tx_full_unchanged", rd, 32'h0000_0824);
    apb_read(32'h04, rd, err);
    check("txdata_read_zero", rd, 32'h0);
    check("txdata_read_err", 32'(err), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("tx_head", 32'(i2c_tx_data), 32'h11 + 32'(i));
      core_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    end
    check("tx_empty_after_drain", 32'(i2c_tx_empty), 32'h1);
    core_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    apb_read(32'h0C, rd, err);
    check("tx_pop_empty_ignored", rd, 32'h0000_0028);

    // 3. config regs, start interlock, done
    apb_write(32'h00, 32'hFFFF_FFA5, err);
    apb_write(32'h08, 32'h0000_0103, err);
    apb_read(32'h00, rd, err);
    check("addr_rb", rd, 32'h0000_00A5);
    check("i2c_addr", 32'(i2c_addr), 32'hA5);
    apb_read(32'h08, rd, err);
    check("cnt_rb", rd, 32'h0000_0003);
    snap = start_cnt;
    apb_write(32'h10, 32'h1, err);
    check("start_err", 32'(err), 32'h0);
    check("start_pulse_hi", 32'(i2c_start), 32'h1);
    @(posedge PCLK); #1;
    check("start_pulse_lo", 32'(i2c_start), 32'h0);
    check("start_pulse_count", 32'(start_cnt - snap), 32'h1);
    apb_read(32'h0C, rd, err);
    check("busy_status", rd, 32'h0000_002A);
    snap = start_cnt;
    apb_write(32'h10, 32'h3, err);
    check("start_busy_err", 32'(err), 32'h1);
    repeat (2) @(posedge PCLK);
    #1;
    check("start_busy_no_pulse", 32'(start_cnt - snap), 32'h0);
    core_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    apb_read(32'h0C, rd, err);
    check("done_status", rd, 32'h0000_0029);
    apb_write(32'h0C, 32'h1, err);
    apb_read(32'h0C, rd, err);
    check("done_w1c", rd, 32'h0000_0028);

    // 4. RX fill with overflow, drain, empty read
    for (int i = 0; i < 9; i++) core_cycle(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
    apb_read(32'h0C, rd, err);
    check("rx_ovf_status", rd, 32'h0008_0058);
    for (int i = 0; i < 8; i++) begin
      apb_read(32'h14, rd, err);
      check("rx_read", rd, 32'hA0 + 32'(i));
    end
    apb_read(32'h14, rd, err);
    check("rx_empty_read_err", 32'(err), 32'h1);
    apb_read(32'h0C, rd, err);
    check("rx_empty_status", rd, 32'h0000_0068);
    apb_write(32'h0C, 32'h40, err);
    apb_read(32'h0C, rd, err);
    check("rx_ovf_w1c", rd, 32'h0000_0028);

    // 5. same-cycle corner cases
    apb_xfer(1'b1, 32'h0C, 32'h1, 1'b1, 1'b0, 1'b0, 8'h00, rd, err);
    apb_read(32'h0C, rd, err);
    check("done_set_wins", rd, 32'h0000_0029);
    apb_write(32'h0C, 32'h1, err);
    for (int i = 0; i < 3; i++) apb_write(32'h04, 32'h31 + 32'(i), err);
    apb_xfer(1'b1, 32'h04, 32'h34, 1'b0, 1'b1, 1'b0, 8'h00, rd, err);
    apb_read(32'h0C, rd, err);
    check("tx_push_pop_level", rd, 32'h0000_0320);
    for (int i = 0; i < 3; i++) begin
      check("tx_push_pop_head", 32'(i2c_tx_data), 32'h32 + 32'(i));
      core_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    end
    core_cycle(1'b0, 1'b0, 1'b1, 8'h51);
    core_cycle(1'b0, 1'b0, 1'b1, 8'h52);
    apb_xfer(1'b1, 32'h10, 32'h4, 1'b0, 1'b0, 1'b1, 8'h53, rd, err);
    apb_read(32'h0C, rd, err);
    check("rx_flush_beats_push", rd, 32'h0000_0028);
    apb_write(32'h04, 32'h61, err);
    apb_write(32'h04, 32'h62, err);
    apb_xfer(1'b1, 32'h10, 32'h2, 1'b0, 1'b1, 1'b0, 8'h00, rd, err);
    apb_read(32'h0C, rd, err);
    check("tx_flush_beats_pop", rd, 32'h0000_0028);

    // 6. optional interrupt register
`ifdef I2C_CSR_IRQ_EN
    apb_write(32'h18, 32'h1, err);
    apb_read(32'h18, rd, err);
    check("irqen_rb", rd, 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    core_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("irq_not_yet", 32'(irq), 32'h0);
    @(posedge PCLK); #1;
    check("irq_set", 32'(irq), 32'h1);
    apb_write(32'h0C, 32'h1, err);
    @(posedge PCLK); #1;
    check("irq_cleared", 32'(irq), 32'h0);
`else
    apb_read(32'h18, rd, err);
    check("irqen_read_err", 32'(err), 32'h1);
    apb_write(32'h18, 32'h1, err);
    check("irqen_write_err", 32'(err), 32'h1);
`endif
    apb_read(32'h1C, rd, err);
    check("unmapped_1c_err", 32'(err), 32'h1);
    apb_read(32'h0C, rd, err);
    check("final_status_err", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
